// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix serializer: default geometry, FSM states
// and the scan-order encoding.
package matrix_pkg;

  localparam int DEF_ROWS       = 12;
  localparam int DEF_COLS       = 12;
  localparam int DEF_DATA_WIDTH = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef enum logic {
    SCAN_ROW = 1'b0,
    SCAN_COL = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/matrix_scan_counter.sv
// Two-level wrapping (row, col) index generator; the scan mode picks which
// index is the fast one. Also flags end-of-line and end-of-matrix.
module matrix_scan_counter
  import matrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    advance,
  input  scan_mode_e              mode,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    eol,
  output logic                    last
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_at_max, col_at_max;

  assign row_at_max = (row_q == ROW_MAX);
  assign col_at_max = (col_q == COL_MAX);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (mode == SCAN_ROW) begin
        if (col_at_max) begin
          col_d = '0;
          row_d = row_at_max ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        if (row_at_max) begin
          row_d = '0;
          col_d = col_at_max ? '0 : col_q + COL_W'(1);
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign eol  = (mode == SCAN_ROW) ? col_at_max : row_at_max;
  assign last = row_at_max && col_at_max;

endmodule

// File: rtl/matrix_serializer.sv
// Captures a parallel ROWS x COLS matrix and streams it element by element,
// row-major or transposed, over a valid/ready interface.
module matrix_serializer
  import matrix_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]   mat_in,
  input  logic                                        mat_valid,
  output logic                                        mat_ready,
  input  logic                                        trans_mode,
  input  logic                                        flush,
  output logic [DATA_WIDTH-1:0]                       out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [$clog2(ROWS)-1:0]                     out_row,
  output logic [$clog2(COLS)-1:0]                     out_col,
  output logic                                        out_eol,
  output logic                                        out_last
);

  state_e     state_q, state_d;
  scan_mode_e mode_q, mode_d;
  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mat_buf_q, mat_buf_d;

  logic accept, handshake, idx_clear, idx_advance;
  logic scan_eol, scan_last;

  assign mat_ready = (state_q == IDLE) && !rst;
  assign accept    = mat_valid && mat_ready;
  assign out_valid = (state_q == STREAM);
  assign handshake = out_valid && out_ready;
  // A flush must not let the element under it count as delivered.
  assign idx_advance = handshake && !flush;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mat_buf_d = mat_buf_q;
    idx_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mat_buf_d = mat_in;
          mode_d    = scan_mode_e'(trans_mode);
          idx_clear = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (flush) begin
          idx_clear = 1'b1;
          state_d   = IDLE;
        end else if (handshake && scan_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= SCAN_ROW;
      mat_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mat_buf_q <= mat_buf_d;
    end
  end

  matrix_scan_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .advance (idx_advance),
    .mode    (mode_q),
    .row     (out_row),
    .col     (out_col),
    .eol     (scan_eol),
    .last    (scan_last)
  );

  assign out_data = mat_buf_q[out_row][out_col];
  assign out_eol  = out_valid && scan_eol;
  assign out_last = out_valid && scan_last;

endmodule

// File: tb/tb_matrix_serializer.sv
// Directed bench for matrix_serializer: element [i][j] = base + 16*i + j.
module tb_matrix_serializer;

  localparam int R  = 12;
  localparam int C  = 12;
  localparam int DW = 64;
  localparam int N  = R * C;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [R-1:0][C-1:0][DW-1:0]  mat_in;
  logic                         mat_valid;
  logic                         mat_ready;
  logic                         trans_mode;
  logic                         flush;
  logic [DW-1:0]                out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [3:0]                   out_row;
  logic [3:0]                   out_col;
  logic                         out_eol;
  logic                         out_last;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matrix_serializer #(
    .ROWS       (R),
    .COLS       (C),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mat_in     (mat_in),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .trans_mode (trans_mode),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_eol    (out_eol),
    .out_last   (out_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] base);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        mat_in[i][j] = base + 64'(16 * i + j);
  endtask

  // Present a matrix from IDLE; trans_mode is flipped afterwards to prove it was latched.
  task automatic send(input logic mode, input logic [63:0] base);
    load(base);
    trans_mode = mode;
    mat_valid  = 1'b1;
    check("send_ready", mat_ready, 1'b1);
    tick();
    mat_valid  = 1'b0;
    trans_mode = ~mode;
  endtask

  // Walk beats k0..k1-1; with stall set, out_ready follows 1,0,0,1 per cycle.
  task automatic stream(input logic mode, input logic [63:0] base,
                        input int k0, input int k1, input bit stall);
    int k;
    int c;
    int i;
    int j;
    bit rdy;
    k = k0;
    c = 0;
    while (k < k1 && c < 4 * N) begin
      if (mode == 1'b0) begin
        i = k / C;
        j = k % C;
      end else begin
        j = k / R;
        i = k % R;
      end
      check("valid", out_valid, 1'b1);
      check("data", out_data, base + 64'(16 * i + j));
      check("row", out_row, 64'(i));
      check("col", out_col, 64'(j));
      check("eol", out_eol, (mode == 1'b0) ? (j == C - 1) : (i == R - 1));
      check("last", out_last, k == N - 1);
      check("busy_ready", mat_ready, 1'b0);
      rdy = stall ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      out_ready = rdy;
      tick();
      if (rdy) k++;
      c++;
    end
    if (k < k1) check("stream_timeout", 64'(k), 64'(k1));
    out_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_ready"}, mat_ready, 1'b1);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_eol"}, out_eol, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    mat_in     = '0;
    mat_valid  = 1'b0;
    trans_mode = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 64'h0);
    check("rst_row", out_row, 64'h0);
    check("rst_col", out_col, 64'h0);
    check("rst_eol", out_eol, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_mready", mat_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_mready", mat_ready, 1'b1);
    tick();

    // Row-major, no back-pressure
    send(1'b0, 64'h0);
    stream(1'b0, 64'h0, 0, N, 1'b0);
    check_idle("m0_end");

    // Column-major
    tick();
    send(1'b1, 64'h0);
    stream(1'b1, 64'h0, 0, N, 1'b0);
    check_idle("m1_end");

    // Back-pressure 1,0,0,1
    send(1'b0, 64'h1000);
    stream(1'b0, 64'h1000, 0, N, 1'b1);
    check_idle("stall_end");

    // Flush at beat 50, then a fresh matrix restarts at (0,0)
    send(1'b0, 64'h0);
    stream(1'b0, 64'h0, 0, 50, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush");
    send(1'b0, 64'hFF00);
    stream(1'b0, 64'hFF00, 0, N, 1'b0);
    check_idle("after_flush");

    // New matrix offered mid-stream must be ignored
    send(1'b1, 64'h0);
    stream(1'b1, 64'h0, 0, 20, 1'b0);
    load(64'hDEAD_0000);
    mat_valid = 1'b1;
    stream(1'b1, 64'h0, 20, 30, 1'b0);
    mat_valid = 1'b0;
    stream(1'b1, 64'h0, 30, N, 1'b0);
    check_idle("ignore_end");

    // Reset at beat 20
    send(1'b0, 64'h0);
    stream(1'b0, 64'h0, 0, 20, 1'b0);
    rst = 1'b1;
    tick();
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_data", out_data, 64'h0);
    check("mrst_row", out_row, 64'h0);
    check("mrst_col", out_col, 64'h0);
    check("mrst_eol", out_eol, 1'b0);
    check("mrst_last", out_last, 1'b0);
    check("mrst_mready", mat_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("mrst_release_ready", mat_ready, 1'b1);
    tick();
    check("mrst_no_valid", out_valid, 1'b0);
    tick();
    check("mrst_no_valid2", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_serializer.md
MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

Interface
REQ-001 SHALL have parameter ROWS, default 12, source matrix row count.
REQ-002 SHALL have parameter COLS, default 12, source matrix column count.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, element width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mat_in  input  ROWS x COLS x DATA_WIDTH  parallel source matrix, indexed [row][col].
REQ-007 SHALL have port mat_valid  input  1  mat_in holds a valid matrix.
REQ-008 SHALL have port mat_ready  output  1  block accepts a matrix this cycle.
REQ-009 SHALL have port trans_mode  input  1  scan order, sampled at acceptance: 0 = row-major (original), 1 = column-major (transposed).
REQ-010 SHALL have port flush  input  1  synchronous abort of the current stream.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  current stream element.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have ports out_row / out_col  output  $clog2(ROWS) / $clog2(COLS)  source indices of out_data.
REQ-015 SHALL have port out_eol  output  1  last element of an output line (last column in mode 0, last row in mode 1).
REQ-016 SHALL have port out_last  output  1  final element of the matrix.

Function
REQ-017 SHALL implement FSM states IDLE and STREAM.
REQ-018 SHALL drive mat_ready = 1 only in IDLE with rst low; mat_in ignored otherwise.
REQ-019 SHALL, on mat_valid && mat_ready, capture mat_in into an internal buffer, latch trans_mode, clear indices to (0,0), and enter STREAM the next cycle.
REQ-020 SHALL assert out_valid in STREAM only; first element (0,0) valid one cycle after acceptance.
REQ-021 SHALL drive out_data = buffer[out_row][out_col] from registered indices (no added latency).
REQ-022 SHALL advance indices only on out_valid && out_ready; out_data, out_row, out_col, out_eol, out_last held stable while out_valid && !out_ready.
REQ-023 SHALL, in mode 0, increment out_col, wrapping COLS-1 -> 0 with out_row incrementing.
REQ-024 SHALL, in mode 1, increment out_row, wrapping ROWS-1 -> 0 with out_col incrementing.
REQ-025 SHALL assert out_last at (ROWS-1, COLS-1) in both modes; out_last implies out_eol.
REQ-026 SHALL, on handshake of the out_last element, return to IDLE next cycle (one idle cycle between matrices; ROWS*COLS+1 cycles per matrix with out_ready held high).
REQ-027 SHALL, on flush in STREAM, drop out_valid and return to IDLE next cycle regardless of out_ready; flush in IDLE has no effect; flush has priority over mat_valid acceptance in the same cycle.
REQ-028 SHALL leave the buffer unchanged while in STREAM, even if mat_in changes.

Reset
REQ-029 SHALL, with rst high, force state IDLE, indices 0, latched mode 0, buffer cleared to 0.
REQ-030 SHALL output during/after reset: out_valid 0, out_data 0, out_row 0, out_col 0, out_eol 0, out_last 0, mat_ready 0 while rst high and 1 the first cycle after.
REQ-031 SHALL abort any in-progress stream on rst mid-operation, with no further out_valid until a new matrix is accepted.

Structure
REQ-032 SHALL place ROWS/COLS/DATA_WIDTH defaults, the FSM state typedef and the scan-mode enum in shared package matrix_pkg.
REQ-033 SHALL implement index generation in sub-module matrix_scan_counter (two-level wrapping counter with mode select, advance enable, eol/last flags).

Verification (element [i][j] = 16*i + j, ROWS=COLS=12)
REQ-034 SHALL verify mode 0, out_ready always 1: 144 beats 0x00,0x01..0x0B,0x10..0xBB; out_eol on every 12th beat; out_last only on 0xBB; out_valid low on beat 145.
REQ-035 SHALL verify mode 1: beats 0x00,0x10..0xB0,0x01..0xBB; out_eol on 0xB0,0xB1,...; out_last on 0xBB.
REQ-036 SHALL verify out_ready toggling 1,0,0,1 per cycle: no element skipped or duplicated; outputs stable during stalls.
REQ-037 SHALL verify flush at beat 50: out_valid low next cycle, mat_ready high; new matrix of 0xFF.. restarts at (0,0).
REQ-038 SHALL verify mat_in changed and mat_valid high mid-stream: mat_ready stays 0, stream values unchanged.
REQ-039 SHALL verify rst at beat 20: all outputs at reset values; mat_ready 1 the cycle after rst falls.
